// File: rtl/car_crash_manager.sv
// car_crash_manager: per-frame bounding-box scan of the AI car slots against
// the player box, followed by a spin-out freeze and a speed ramp-up on a hit.
module car_crash_manager #(
   parameter int NUM_CARS    = 4,
   parameter int SPIN_FRAMES = 60,
   parameter int RAMP_STEP   = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             frame_start,
   input  logic [NUM_CARS-1:0][4:0][10:0]   car_states,
   input  logic [10:0]                      player_x,
   input  logic [10:0]                      player_y,
   input  logic [10:0]                      player_w,
   input  logic [10:0]                      player_h,
   input  logic [9:0]                       player_speed_req,
   output logic [9:0]                       player_speed,
   output logic                             crash_active,
   output logic                             crash_pulse,
   output logic [2:0]                       hit_car_idx,
   output logic [7:0]                       crash_count,
   output logic                             scan_done
);

   typedef enum logic [1:0] {DRIVE, SCAN, SPIN, RECOVER} state_t;

   state_t        state, next_state;
   logic [2:0]    idx;
   logic          hit_found;
   logic [2:0]    hit_idx;
   logic [15:0]   spin_cnt;

   logic [NUM_CARS-1:0] slot_hit;
   logic          cur_hit;
   logic          last_slot;
   logic          final_hit;
   logic [2:0]    final_idx;
   logic [10:0]   ramp_sum;
   logic [9:0]    ramp_speed;
   logic          req_below;

   // Player box far edges, widened by one bit so the sums never wrap.
   logic [11:0]   p_right, p_bottom;
   assign p_right  = {1'b0, player_x} + {1'b0, player_w};
   assign p_bottom = {1'b0, player_y} + {1'b0, player_h};

   // Strict-inequality overlap per slot; touching edges and empty slots never hit.
   for (genvar i = 0; i < NUM_CARS; i++) begin : g_slot
      logic [11:0] c_right, c_bottom;
      assign c_right  = {1'b0, car_states[i][1]} + {1'b0, car_states[i][3]};
      assign c_bottom = {1'b0, car_states[i][2]} + {1'b0, car_states[i][4]};
      assign slot_hit[i] = (car_states[i][0] != 11'd0)
                        && ({1'b0, player_x} < c_right)
                        && ({1'b0, car_states[i][1]} < p_right)
                        && ({1'b0, player_y} < c_bottom)
                        && ({1'b0, car_states[i][2]} < p_bottom);
   end

   // Select the slot under test and fold it into the running first-hit record.
   always_comb begin
      cur_hit = 1'b0;
      for (int i = 0; i < NUM_CARS; i++)
         if (idx == 3'(i)) cur_hit = slot_hit[i];
      last_slot  = (idx == 3'(NUM_CARS - 1));
      final_hit  = hit_found | cur_hit;
      final_idx  = hit_found ? hit_idx : idx;
      ramp_sum   = {1'b0, player_speed} + 11'(RAMP_STEP);
      ramp_speed = (ramp_sum > {1'b0, player_speed_req}) ? player_speed_req : ramp_sum[9:0];
      req_below  = (player_speed_req < player_speed);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= DRIVE;
      else       state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         DRIVE:   if (frame_start) next_state = SCAN;
         SCAN:    if (last_slot) next_state = final_hit ? SPIN : DRIVE;
         SPIN:    if (frame_start && spin_cnt <= 16'd1) next_state = RECOVER;
         RECOVER: begin
            if (req_below)
               next_state = DRIVE;
            else if (frame_start && ramp_speed == player_speed_req)
               next_state = DRIVE;
         end
         default: next_state = DRIVE;
      endcase
   end

   // Datapath: scan bookkeeping, crash reporting, spin counter and speed.
   always_ff @(posedge clk) begin
      if (reset) begin
         player_speed <= '0;
         hit_car_idx  <= '0;
         crash_count  <= '0;
         crash_active <= 1'b0;
         crash_pulse  <= 1'b0;
         scan_done    <= 1'b0;
         idx          <= '0;
         hit_found    <= 1'b0;
         hit_idx      <= '0;
         spin_cnt     <= '0;
      end else begin
         crash_pulse  <= 1'b0;
         scan_done    <= 1'b0;
         crash_active <= (next_state == SPIN) || (next_state == RECOVER);
         case (state)
            DRIVE: begin
               player_speed <= player_speed_req;
               if (frame_start) begin
                  idx       <= '0;
                  hit_found <= 1'b0;
               end
            end
            SCAN: begin
               player_speed <= player_speed_req;
               idx          <= idx + 3'd1;
               if (cur_hit && !hit_found) begin
                  hit_found <= 1'b1;
                  hit_idx   <= idx;
               end
               if (last_slot) begin
                  scan_done <= 1'b1;
                  if (final_hit) begin
                     hit_car_idx  <= final_idx;
                     crash_pulse  <= 1'b1;
                     if (crash_count != 8'hFF) crash_count <= crash_count + 8'd1;
                     spin_cnt     <= 16'(SPIN_FRAMES);
                     player_speed <= '0;
                  end
               end
            end
            SPIN: begin
               player_speed <= '0;
               if (frame_start && spin_cnt != 16'd0) spin_cnt <= spin_cnt - 16'd1;
            end
            RECOVER: begin
               if (req_below)        player_speed <= player_speed_req;
               else if (frame_start) player_speed <= ramp_speed;
            end
            default: player_speed <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_car_crash_manager.sv
// Directed bench for car_crash_manager: scan timing, overlap edge cases,
// full spin/recover sequence, reset mid-spin, clamp and counter saturation.
module tb_car_crash_manager;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    frame_start;
   logic [3:0][4:0][10:0]   car_states;
   logic [10:0]             player_x, player_y, player_w, player_h;
   logic [9:0]              player_speed_req;
   logic [9:0]              player_speed;
   logic                    crash_active, crash_pulse, scan_done;
   logic [2:0]              hit_car_idx;
   logic [7:0]              crash_count;

   int checks   = 0;
   int failures = 0;
   int n_pulse  = 0;
   int n_scan   = 0;
   int snap_pulse, snap_scan;

   car_crash_manager #(.NUM_CARS(4), .SPIN_FRAMES(60), .RAMP_STEP(16)) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .car_states(car_states),
      .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
      .player_speed_req(player_speed_req), .player_speed(player_speed),
      .crash_active(crash_active), .crash_pulse(crash_pulse), .hit_car_idx(hit_car_idx),
      .crash_count(crash_count), .scan_done(scan_done)
   );

   always #5 clk = ~clk;

   // Count output pulses seen at each edge.
   always @(posedge clk) begin
      if (crash_pulse) n_pulse <= n_pulse + 1;
      if (scan_done)   n_scan  <= n_scan + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_slot(input int i, input int img, input int x, input int y,
                           input int w, input int h);
      car_states[i][0] = 11'(img);
      car_states[i][1] = 11'(x);
      car_states[i][2] = 11'(y);
      car_states[i][3] = 11'(w);
      car_states[i][4] = 11'(h);
   endtask

   task automatic clear_slots();
      for (int i = 0; i < 4; i++) set_slot(i, 0, 0, 0, 0, 0);
   endtask

   // frame_start edge plus four slot-test edges; returns sampled after the last.
   task automatic run_scan();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (4) tick();
   endtask

   // One frame: frame_start for a cycle followed by two idle cycles.
   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      reset = 1'b1;
      frame_start = 1'b0;
      clear_slots();
      player_x = 11'd256; player_y = 11'd380; player_w = 11'd64; player_h = 11'd128;
      player_speed_req = 10'd200;
      repeat (2) tick();
      check("rst_speed", 32'(player_speed), 0);
      check("rst_active", 32'(crash_active), 0);
      check("rst_pulse", 32'(crash_pulse), 0);
      check("rst_scan_done", 32'(scan_done), 0);
      check("rst_count", 32'(crash_count), 0);
      check("rst_hit_idx", 32'(hit_car_idx), 0);
      reset = 1'b0;
      tick();
      check("drive_follow", 32'(player_speed), 200);

      // Touching edges: slot 0 starts exactly at the player's right edge.
      set_slot(0, 1, 320, 380, 64, 128);
      run_scan();
      check("touch_scan_done", 32'(scan_done), 1);
      check("touch_no_pulse", 32'(crash_pulse), 0);
      check("touch_speed", 32'(player_speed), 200);
      tick();
      check("touch_active", 32'(crash_active), 0);

      // Head-on overlap in slot 2, with per-cycle scan timing.
      clear_slots();
      set_slot(2, 1, 256, 380, 64, 128);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         check($sformatf("head_early_done_c%0d", c), 32'(scan_done), 0);
         check($sformatf("head_early_pulse_c%0d", c), 32'(crash_pulse), 0);
      end
      tick();
      check("head_scan_done", 32'(scan_done), 1);
      check("head_pulse", 32'(crash_pulse), 1);
      check("head_hit_idx", 32'(hit_car_idx), 2);
      check("head_count", 32'(crash_count), 1);
      check("head_speed", 32'(player_speed), 0);
      check("head_active", 32'(crash_active), 1);
      tick();
      check("head_pulse_one_cycle", 32'(crash_pulse), 0);

      // Spin with overlap still present: frozen, no scans, no second crash.
      snap_pulse = n_pulse;
      snap_scan  = n_scan;
      for (int k = 1; k <= 60; k++) begin
         frame();
         check($sformatf("spin_speed_f%0d", k), 32'(player_speed), 0);
      end
      check("spin_no_pulse", 32'(n_pulse), 32'(snap_pulse));
      check("spin_no_scan", 32'(n_scan), 32'(snap_scan));
      check("spin_count", 32'(crash_count), 1);

      // Recovery ramp 16, 32, ..., 192, 200.
      for (int k = 1; k <= 13; k++) begin
         frame();
         check($sformatf("rec_speed_f%0d", k), 32'(player_speed), (16 * k > 200) ? 200 : 16 * k);
         check($sformatf("rec_active_f%0d", k), 32'(crash_active), (k < 13) ? 1 : 0);
      end
      check("rec_no_pulse", 32'(n_pulse), 32'(snap_pulse));

      // Inactive slot 0 overlaps but must be skipped; slot 3 is the hit.
      clear_slots();
      set_slot(0, 0, 256, 380, 64, 128);
      set_slot(3, 5, 280, 400, 64, 128);
      run_scan();
      check("inact_pulse", 32'(crash_pulse), 1);
      check("inact_hit_idx", 32'(hit_car_idx), 3);
      check("inact_count", 32'(crash_count), 2);

      // Reset mid-spin after 30 frames.
      for (int k = 1; k <= 30; k++) frame();
      check("mid_spin_active", 32'(crash_active), 1);
      snap_pulse = n_pulse;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_active", 32'(crash_active), 0);
      check("rst_mid_speed", 32'(player_speed), 0);
      check("rst_mid_count", 32'(crash_count), 0);
      check("rst_mid_pulse", 32'(crash_pulse), 0);
      player_speed_req = 10'd123;
      tick();
      check("rst_mid_follow", 32'(player_speed), 123);
      repeat (3) tick();
      check("rst_mid_no_pulse", 32'(n_pulse), 32'(snap_pulse));
      player_speed_req = 10'd200;

      // Slots 1 and 3 both overlap: the lower index wins.
      clear_slots();
      set_slot(1, 2, 200, 300, 100, 100);
      set_slot(3, 4, 256, 380, 64, 128);
      run_scan();
      check("multi_pulse", 32'(crash_pulse), 1);
      check("multi_hit_idx", 32'(hit_car_idx), 1);
      check("multi_count", 32'(crash_count), 1);

      // Spin out, two ramp frames, then a request drop clamps and exits.
      for (int k = 1; k <= 62; k++) frame();
      check("clamp_pre_speed", 32'(player_speed), 32);
      check("clamp_pre_active", 32'(crash_active), 1);
      player_speed_req = 10'd20;
      tick();
      check("clamp_speed", 32'(player_speed), 20);
      check("clamp_active", 32'(crash_active), 0);

      // Saturation: continuous frame_start, zero request so recovery is immediate.
      reset = 1'b1;
      player_speed_req = 10'd0;
      tick();
      reset = 1'b0;
      clear_slots();
      set_slot(3, 1, 256, 380, 64, 128);
      frame_start = 1'b1;
      repeat (300 * 66) tick();
      frame_start = 1'b0;
      check("sat_count", 32'(crash_count), 255);
      check("sat_pulses_past_255", 32'(n_pulse - snap_pulse) > 32'd256 ? 32'd1 : 32'd0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/car_crash_manager.md
Name: car_crash_manager

Overview:
- Sits directly downstream of the AI car/truck sprite blocks. Consumes their per-frame car-state vectors (img_id, x, y, width, height) together with the player car's box.
- Once per frame it scans every car for a bounding-box overlap with the player. On a hit it runs a crash sequence: spin-out freeze, then a speed ramp-up.
- Drives the player speed used by the road-scroll and AI-car logic.

Parameters:
- NUM_CARS, 4, number of AI car-state slots scanned per frame (1..8).
- SPIN_FRAMES, 60, number of frames the player speed is held at 0 after a crash.
- RAMP_STEP, 16, speed increment applied per frame during recovery.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse at the start of each video frame.
- car_states  in  NUM_CARS x 5 x 11  per-slot packed state. Field [0] img_id (0 = slot inactive), [1] x, [2] y, [3] width, [4] height.
- player_x  in  11  player box left edge.
- player_y  in  11  player box top edge.
- player_w  in  11  player box width.
- player_h  in  11  player box height.
- player_speed_req  in  10  speed requested by the throttle logic.
- player_speed  out  10  effective speed distributed to the game.
- crash_active  out  1  high in SPIN and RECOVER.
- crash_pulse  out  1  one-cycle pulse when a crash is accepted.
- hit_car_idx  out  3  slot index of the last accepted crash.
- crash_count  out  8  saturating count of accepted crashes.
- scan_done  out  1  one-cycle pulse when a scan completes, hit or not.

Behaviour:
- Reset (synchronous, active-high) values:
  - state = DRIVE.
  - player_speed, hit_car_idx, crash_count = 0.
  - crash_active, crash_pulse, scan_done = 0.
  - Internal scan index and hit flag cleared.
  - Reset asserted in any state, including mid-scan or mid-spin, aborts the state on the next edge. Any recorded hit is discarded.
- Overlap test for slot i uses strict inequality on all four conditions, with 12-bit sums so there is no wrap:
  - player_x < car_x + car_w
  - car_x < player_x + player_w
  - player_y < car_y + car_h
  - car_y < player_y + player_h
  - Edges that only touch are not a hit.
  - A slot with img_id == 0 never hits.
- FSM states are DRIVE, SCAN, SPIN, RECOVER.
- DRIVE:
  - player_speed <= player_speed_req every cycle (1-cycle latency).
  - On frame_start: go to SCAN with idx = 0 and hit flag = 0.
- SCAN:
  - Tests one slot per cycle, slot idx. Inputs are sampled in the cycle that slot is tested.
  - The first hitting slot, i.e. the lowest index, is recorded. Later hits in the same scan are ignored.
  - player_speed keeps tracking player_speed_req.
  - frame_start arriving during SCAN is ignored.
  - After slot NUM_CARS-1 is tested, scan_done pulses for 1 cycle.
  - If a hit was recorded:
    - hit_car_idx <= recorded index.
    - crash_pulse = 1 for that same cycle.
    - crash_count increments, saturating at 255.
    - spin counter <= SPIN_FRAMES.
    - player_speed <= 0.
    - Go to SPIN.
  - If no hit: go to DRIVE.
  - A scan lasts exactly NUM_CARS cycles from the frame_start edge.
- SPIN:
  - player_speed held at 0.
  - The spin counter decrements on each frame_start.
  - The frame_start on which the counter reaches 0 moves the FSM to RECOVER.
  - No scanning takes place: the player is invulnerable.
- RECOVER:
  - No scanning: the player is invulnerable.
  - On each frame_start: player_speed <= min(player_speed + RAMP_STEP, player_speed_req), computed in 11 bits.
  - When the updated value equals player_speed_req, go to DRIVE.
  - If player_speed_req drops below player_speed, player_speed is clamped to player_speed_req on the next cycle and the FSM goes to DRIVE.
  - If player_speed_req == 0 on entry, the FSM goes to DRIVE on the first frame_start.
- crash_active = (state == SPIN or state == RECOVER). It is registered and aligned with the state register.

Test Plan:
- Head-on overlap:
  - Stimulus: player (256,380,64,128); slot 2 = {1,256,380,64,128}; others img_id 0; player_speed_req = 200; frame_start.
  - Required: scan_done and crash_pulse in cycle 4 after frame_start; hit_car_idx = 2; crash_count = 1; player_speed = 0; crash_active = 1.
- Touching edges:
  - Stimulus: slot 0 x = 320, all else as in the head-on case.
  - Required: scan_done pulses; no crash_pulse; player_speed stays 200.
- Inactive slot and multiple hits:
  - Stimulus: slots 0 and 3 overlap the player; slot 0 has img_id 0.
  - Required: hit_car_idx = 3.
  - Stimulus: slots 1 and 3 both active and overlapping.
  - Required: hit_car_idx = 1.
- Full crash sequence (SPIN_FRAMES = 60, RAMP_STEP = 16, player_speed_req = 200):
  - Required: speed 0 for 60 frame_starts with no scans and no second crash_pulse even while overlap persists.
  - Then speed goes 16, 32, ..., 192, 200; DRIVE and crash_active = 0 on the 13th recovery frame.
- Reset mid-SPIN:
  - Stimulus: assert reset for 1 cycle at spin count 30.
  - Required: state DRIVE; player_speed 0, then it follows player_speed_req; crash_count = 0; no crash_pulse.
- Counter saturation:
  - Stimulus: force 256 crash sequences.
  - Required: crash_count holds at 255.
